dtw_word_assembler: RTL and testbench
=====================================

// Module: dtw_word_assembler
// PURPOSE
//  Upstream feeder of the DTW word matcher. Collects recognised glove characters (8-bit ASCII, one per
//  handshake) into a 15-char zero-padded word, commits on space, launches DTW, waits for its finish pulse,
//  returns the corrected word to the consumer via valid/ready. Falls back to raw word on DTW timeout.
// PARAMETERS
//  CHAR_NUM        15    max chars per word; word bus = CHAR_NUM*8 bits
//  TIMEOUT_CYCLES  2048  cycles in S_WAIT before giving up on DTW finish
// PORTS
//  i_WA_clk          in   1    single clock, all logic on posedge
//  i_WA_rst_n        in   1    reset, synchronous, active-low
//  i_WA_char_valid   in   1    upstream char valid
//  i_WA_char         in   8    ASCII char; 8'h20 = commit, 8'h08 = backspace, 8'h00 = ignored
//  o_WA_char_ready   out  1    char accepted when valid&&ready
//  o_WA_dtw_start    out  1    one-cycle start pulse to DTW
//  o_WA_dtw_word     out  120  buffered word to DTW; char k at [8k+7:8k], unused chars 8'h00
//  i_WA_dtw_finish   in   1    DTW done pulse (1 cycle)
//  i_WA_dtw_word     in   120  DTW best-match word, sampled on finish
//  o_WA_word_valid   out  1    corrected word available
//  o_WA_word         out  120  corrected (or raw on timeout) word
//  i_WA_word_ready   in   1    consumer accepts word
//  o_WA_timeout      out  1    qualifies o_WA_word: 1 = DTW timed out, word is raw buffer
//  o_WA_overflow     out  1    one-cycle pulse: letter dropped, buffer full
//  o_WA_len          out  4    current buffered char count 0..CHAR_NUM
// BEHAVIOUR
//  Reset (i_WA_rst_n==0 at posedge): state=S_COLLECT, buffer=0, len=0, timer=0; all outputs 0;
//   o_WA_char_ready forced 0 while i_WA_rst_n low.
//  S_COLLECT: ready=1. On accepted char (effects visible next cycle):
//   letter (not 20/08/00): len<CHAR_NUM -> write at slot len, len+1; len==CHAR_NUM -> drop, overflow pulse.
//   08: len>0 -> clear slot len-1, len-1; len==0 -> no effect.
//   00: no effect.  20: len>0 -> S_START; len==0 -> ignored, stay.
//  S_START (1 cycle): ready=0, dtw_start=1, timer cleared -> S_WAIT.
//  S_WAIT: ready=0, timer+1 per cycle. finish=1 -> result<=i_WA_dtw_word, timeout_flag<=0 -> S_OUT.
//   timer==TIMEOUT_CYCLES-1 without finish -> result<=buffer, timeout_flag<=1 -> S_OUT.
//   finish on the timeout cycle: finish wins. finish outside S_WAIT: ignored.
//  S_OUT: word_valid=1, o_WA_word/o_WA_timeout held stable until valid&&ready; on transfer buffer, len
//   cleared, -> S_COLLECT (ready=1 next cycle). No skid: chars stall from S_START through S_OUT.
//  o_WA_dtw_word = buffer; stable from S_START until leaving S_WAIT (DTW reads it throughout).
//  Timer width $clog2(TIMEOUT_CYCLES+1); len saturates at CHAR_NUM, never wraps.
//  Reset mid-operation: immediate return to reset values at next edge; any pending DTW result discarded.
// CONFIGURATION
//  `WA_DEDUP_EN defined: in S_COLLECT a letter equal to slot len-1 (len>0) is dropped (no overflow
//   pulse) -- suppresses held-gesture repeats. Backspace/commit unaffected.
//  Not defined: every letter stored, repeats included.
// STRUCTURE
//  Package wa_pkg: CHAR_W=8, CHAR_NUM, WORD_W=CHAR_NUM*8, CH_COMMIT=8'h20, CH_BKSP=8'h08,
//   CH_NULL=8'h00, state enum {S_COLLECT,S_START,S_WAIT,S_OUT}.
//  Sub-module wa_watchdog: clear/enable/expire counter parameterised by TIMEOUT_CYCLES.
//  Top: FSM + buffer/len regs + output register; two-process (comb next-state, ff update).
// TESTING
//  1. "CAT"+20, DTW finish after 40 cycles returning "CAT" -> one start pulse, word_valid with
//     word=0x...544143, timeout=0, len=0 after transfer.
//  2. "CAX",08,"T",20 -> o_WA_dtw_word=0x544143 at start; 08 at len=0 -> len stays 0.
//  3. 16 letters -> len=15, one overflow pulse on 16th, 16th char absent from word.
//  4. 20 with len=0 -> no start pulse; commit "AB" with no finish -> after 2048 cycles
//     word_valid=1, timeout=1, word=0x4241.
//  5. word_valid held with ready=0 for 10 cycles -> word stable, char_ready=0; rst_n low mid-S_WAIT
//     -> all outputs 0 next edge, later finish ignored.
//  6. `WA_DEDUP_EN: "HELLO"+20 -> word "HELO"; undefined -> "HELLO".

Source files
------------

// File: rtl/dtw_word_assembler_pkg.sv
// Shared constants, state encoding and character classification for the DTW word assembler.
package wa_pkg;
   localparam int CHAR_W   = 8;
   localparam int CHAR_NUM = 15;
   localparam int WORD_W   = CHAR_NUM * CHAR_W;
   localparam int LEN_W    = $clog2(CHAR_NUM + 1);

   localparam logic [CHAR_W-1:0] CH_COMMIT = 8'h20;
   localparam logic [CHAR_W-1:0] CH_BKSP   = 8'h08;
   localparam logic [CHAR_W-1:0] CH_NULL   = 8'h00;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_START   = 2'd1,
      S_WAIT    = 2'd2,
      S_OUT     = 2'd3
   } wa_state_e;

   // Anything that is not a control code is stored as a letter.
   function automatic logic is_letter(input logic [CHAR_W-1:0] c);
      return (c != CH_COMMIT) && (c != CH_BKSP) && (c != CH_NULL);
   endfunction
endpackage

// File: rtl/dtw_word_assembler_if.sv
// Character input, DTW launch/result and corrected-word output bundle of the word assembler.
interface dtw_word_assembler_if;
   import wa_pkg::*;

   logic                 i_WA_char_valid;
   logic [CHAR_W-1:0]    i_WA_char;
   logic                 o_WA_char_ready;
   logic                 o_WA_dtw_start;
   logic [WORD_W-1:0]    o_WA_dtw_word;
   logic                 i_WA_dtw_finish;
   logic [WORD_W-1:0]    i_WA_dtw_word;
   logic                 o_WA_word_valid;
   logic [WORD_W-1:0]    o_WA_word;
   logic                 i_WA_word_ready;
   logic                 o_WA_timeout;
   logic                 o_WA_overflow;
   logic [LEN_W-1:0]     o_WA_len;

   modport slave (
      input  i_WA_char_valid, i_WA_char, i_WA_dtw_finish, i_WA_dtw_word, i_WA_word_ready,
      output o_WA_char_ready, o_WA_dtw_start, o_WA_dtw_word, o_WA_word_valid, o_WA_word,
             o_WA_timeout, o_WA_overflow, o_WA_len
   );

   modport master (
      output i_WA_char_valid, i_WA_char, i_WA_dtw_finish, i_WA_dtw_word, i_WA_word_ready,
      input  o_WA_char_ready, o_WA_dtw_start, o_WA_dtw_word, o_WA_word_valid, o_WA_word,
             o_WA_timeout, o_WA_overflow, o_WA_len
   );
endinterface

// File: rtl/dtw_word_assembler_watchdog.sv
// Clear/enable counter that flags the last permitted wait cycle for the DTW finish pulse.
module wa_watchdog #(
   parameter int TIMEOUT_CYCLES = 2048
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Next count: clear wins, otherwise count while enabled and hold at the last cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + TMR_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = en && (cnt_q == LAST);
endmodule

// File: rtl/dtw_word_assembler.sv
// Collects glove characters into a zero-padded word, hands it to DTW and returns the corrected word.
// Optional build macro WA_DEDUP_EN drops a letter equal to the previously stored one.
module dtw_word_assembler
   import wa_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2048
) (
   input  logic                 i_WA_clk,
   input  logic                 i_WA_rst_n,
   dtw_word_assembler_if.slave  bus
);
   wa_state_e         state_q,    state_d;
   logic [WORD_W-1:0] buf_q,      buf_d;
   logic [LEN_W-1:0]  len_q,      len_d;
   logic [WORD_W-1:0] result_q,   result_d;
   logic              timeout_q,  timeout_d;
   logic              overflow_q, overflow_d;
   logic              wd_clr_s;
   logic              wd_en_s;
   logic              wd_expire_s;
   logic              is_dup_s;

   wa_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk    (i_WA_clk),
      .rst_n  (i_WA_rst_n),
      .clr    (wd_clr_s),
      .en     (wd_en_s),
      .expire (wd_expire_s)
   );

`ifdef WA_DEDUP_EN
   // A held gesture repeats the same letter; compare against the last stored slot.
   always_comb begin
      if (len_q != '0) begin
         is_dup_s = (buf_q[(int'(len_q) - 1) * CHAR_W +: CHAR_W] == bus.i_WA_char);
      end else begin
         is_dup_s = 1'b0;
      end
   end
`else
   assign is_dup_s = 1'b0;
`endif

   // Next-state, buffer editing and result capture.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      len_d      = len_q;
      result_d   = result_q;
      timeout_d  = timeout_q;
      overflow_d = 1'b0;
      wd_clr_s   = 1'b0;
      wd_en_s    = 1'b0;
      case (state_q)
         S_COLLECT: begin
            if (bus.i_WA_char_valid) begin
               if (is_letter(bus.i_WA_char)) begin
                  if (is_dup_s) begin
                     len_d = len_q;
                  end else if (len_q < LEN_W'(CHAR_NUM)) begin
                     buf_d[int'(len_q) * CHAR_W +: CHAR_W] = bus.i_WA_char;
                     len_d = len_q + LEN_W'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end else if (bus.i_WA_char == CH_BKSP) begin
                  if (len_q != '0) begin
                     buf_d[(int'(len_q) - 1) * CHAR_W +: CHAR_W] = CH_NULL;
                     len_d = len_q - LEN_W'(1);
                  end else begin
                     len_d = len_q;
                  end
               end else if (bus.i_WA_char == CH_COMMIT) begin
                  if (len_q != '0) begin
                     state_d = S_START;
                  end else begin
                     state_d = S_COLLECT;
                  end
               end else begin
                  state_d = S_COLLECT;
               end
            end else begin
               state_d = S_COLLECT;
            end
         end
         S_START: begin
            wd_clr_s = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            wd_en_s = 1'b1;
            // A finish arriving on the expiry cycle still delivers the DTW result.
            if (bus.i_WA_dtw_finish) begin
               result_d  = bus.i_WA_dtw_word;
               timeout_d = 1'b0;
               state_d   = S_OUT;
            end else if (wd_expire_s) begin
               result_d  = buf_q;
               timeout_d = 1'b1;
               state_d   = S_OUT;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_OUT: begin
            if (bus.i_WA_word_ready) begin
               buf_d   = '0;
               len_d   = '0;
               state_d = S_COLLECT;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d = S_COLLECT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_WA_clk) begin
      if (!i_WA_rst_n) begin
         state_q    <= S_COLLECT;
         buf_q      <= '0;
         len_q      <= '0;
         result_q   <= '0;
         timeout_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         len_q      <= len_d;
         result_q   <= result_d;
         timeout_q  <= timeout_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.o_WA_char_ready = i_WA_rst_n && (state_q == S_COLLECT);
   assign bus.o_WA_dtw_start  = (state_q == S_START);
   assign bus.o_WA_dtw_word   = buf_q;
   assign bus.o_WA_word_valid = (state_q == S_OUT);
   assign bus.o_WA_word       = result_q;
   assign bus.o_WA_timeout    = timeout_q;
   assign bus.o_WA_overflow   = overflow_q;
   assign bus.o_WA_len        = len_q;
endmodule

// File: tb/tb_dtw_word_assembler.sv
// Bench for dtw_word_assembler: vector table, corner-case sequences and random words against a queue model.
module tb_dtw_word_assembler;
   import wa_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dtw_word_assembler_if bus ();

   dtw_word_assembler #(.TIMEOUT_CYCLES(2048)) dut (
      .i_WA_clk   (clk),
      .i_WA_rst_n (rst_n),
      .bus        (bus)
   );

`ifdef WA_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   typedef struct {
      string seq;
      string exp_s;
      int    exp_len;
      int    exp_ovf;
      int    delay;
      string ret_s;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int ovf_seen = 0;
   byte unsigned mq[$];
   vec_t vecs[5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [119:0] mk(input string s);
      logic [119:0] w = '0;
      for (int i = 0; i < s.len() && i < 15; i++) w[8*i +: 8] = s[i];
      return w;
   endfunction

   function automatic logic [119:0] pack_q();
      logic [119:0] w = '0;
      for (int i = 0; i < mq.size() && i < 15; i++) w[8*i +: 8] = mq[i];
      return w;
   endfunction

   function automatic byte unsigned map_c(input byte unsigned c);
      if (c == "<") return 8'h08;
      if (c == "_") return 8'h00;
      return c;
   endfunction

   // Handshake one character; entered and left on a negative edge.
   task automatic send_raw(input byte unsigned c);
      int g = 0;
      bus.i_WA_char_valid = 1'b1;
      bus.i_WA_char = c;
      while (!bus.o_WA_char_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) chk("char_ready_wait", {127'd0, bus.o_WA_char_ready}, 128'd1);
      @(negedge clk);
      bus.i_WA_char_valid = 1'b0;
      bus.i_WA_char = 8'h00;
   endtask

   // Model: word is a list of bytes, edited by letters and backspace.
   task automatic send_char(input byte unsigned c);
      bit exp_ovf = 1'b0;
      if (c != 8'h20 && c != 8'h08 && c != 8'h00) begin
         if (DEDUP && mq.size() > 0 && mq[mq.size()-1] == c) exp_ovf = 1'b0;
         else if (mq.size() < 15) mq.push_back(c);
         else exp_ovf = 1'b1;
      end else if (c == 8'h08) begin
         if (mq.size() > 0) void'(mq.pop_back());
      end
      send_raw(c);
      if (bus.o_WA_overflow) ovf_seen++;
      chk("overflow", {127'd0, bus.o_WA_overflow}, {127'd0, exp_ovf});
      chk("len", {124'd0, bus.o_WA_len}, 128'(mq.size()));
   endtask

   task automatic do_commit(input bit use_fin, input int delay, input logic [119:0] exp_buf,
                            input logic [119:0] ret, input int stall);
      logic [119:0] exp_out;
      bit exp_to;
      int n = 0;
      send_raw(8'h20);
      chk("start_pulse", {127'd0, bus.o_WA_dtw_start}, 128'd1);
      chk("dtw_word_at_start", {8'd0, bus.o_WA_dtw_word}, {8'd0, exp_buf});
      chk("ready_in_start", {127'd0, bus.o_WA_char_ready}, 128'd0);
      if (use_fin) begin
         @(negedge clk);
         chk("start_one_cycle", {127'd0, bus.o_WA_dtw_start}, 128'd0);
         repeat (delay) @(negedge clk);
         chk("dtw_word_in_wait", {8'd0, bus.o_WA_dtw_word}, {8'd0, exp_buf});
         bus.i_WA_dtw_finish = 1'b1;
         bus.i_WA_dtw_word = ret;
         @(negedge clk);
         bus.i_WA_dtw_finish = 1'b0;
         exp_out = ret;
         exp_to = 1'b0;
      end else begin
         while (!bus.o_WA_word_valid && n < 2300) begin
            @(negedge clk);
            n++;
         end
         chk("timeout_latency", 128'(n), 128'd2049);
         exp_out = exp_buf;
         exp_to = 1'b1;
      end
      chk("word_valid", {127'd0, bus.o_WA_word_valid}, 128'd1);
      chk("word", {8'd0, bus.o_WA_word}, {8'd0, exp_out});
      chk("timeout_flag", {127'd0, bus.o_WA_timeout}, {127'd0, exp_to});
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("hold_valid", {127'd0, bus.o_WA_word_valid}, 128'd1);
         chk("hold_word", {8'd0, bus.o_WA_word}, {8'd0, exp_out});
         chk("hold_ready", {127'd0, bus.o_WA_char_ready}, 128'd0);
      end
      bus.i_WA_word_ready = 1'b1;
      @(negedge clk);
      bus.i_WA_word_ready = 1'b0;
      mq.delete();
      chk("valid_after_xfer", {127'd0, bus.o_WA_word_valid}, 128'd0);
      chk("len_after_xfer", {124'd0, bus.o_WA_len}, 128'd0);
      chk("ready_after_xfer", {127'd0, bus.o_WA_char_ready}, 128'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [127:0] r;
      int nch;
      byte unsigned c;

      vecs[0] = '{seq: "CAT", exp_s: "CAT", exp_len: 3, exp_ovf: 0, delay: 40, ret_s: "CAT"};
      vecs[1] = '{seq: "<CAX<T", exp_s: "CAT", exp_len: 3, exp_ovf: 0, delay: 5, ret_s: "COT"};
      vecs[2] = '{seq: "ABCDEFGHIJKLMNOP", exp_s: "ABCDEFGHIJKLMNO", exp_len: 15, exp_ovf: 1,
                  delay: 0, ret_s: "ALPHABET"};
      vecs[3] = '{seq: "HELLO", exp_s: DEDUP ? "HELO" : "HELLO", exp_len: DEDUP ? 4 : 5,
                  exp_ovf: 0, delay: 12, ret_s: "HELLO"};
      vecs[4] = '{seq: "Q_R", exp_s: "QR", exp_len: 2, exp_ovf: 0, delay: 3, ret_s: "QR"};

      bus.i_WA_char_valid = 1'b0;
      bus.i_WA_char = 8'h00;
      bus.i_WA_dtw_finish = 1'b0;
      bus.i_WA_dtw_word = '0;
      bus.i_WA_word_ready = 1'b0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {127'd0, bus.o_WA_char_ready}, 128'd0);
      chk("rst_valid", {127'd0, bus.o_WA_word_valid}, 128'd0);
      chk("rst_len", {124'd0, bus.o_WA_len}, 128'd0);
      chk("rst_dtw_word", {8'd0, bus.o_WA_dtw_word}, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {127'd0, bus.o_WA_char_ready}, 128'd1);

      for (int v = 0; v < 5; v++) begin
         ovf_seen = 0;
         for (int i = 0; i < vecs[v].seq.len(); i++) send_char(map_c(vecs[v].seq[i]));
         chk($sformatf("vec%0d_len", v), {124'd0, bus.o_WA_len}, 128'(vecs[v].exp_len));
         chk($sformatf("vec%0d_ovf_count", v), 128'(ovf_seen), 128'(vecs[v].exp_ovf));
         do_commit(1'b1, vecs[v].delay, mk(vecs[v].exp_s), mk(vecs[v].ret_s), 1);
      end

      // Commit on an empty word is ignored; then a word with no DTW answer times out.
      send_raw(8'h20);
      chk("empty_commit_no_start", {127'd0, bus.o_WA_dtw_start}, 128'd0);
      chk("empty_commit_ready", {127'd0, bus.o_WA_char_ready}, 128'd1);
      send_char("A");
      send_char("B");
      do_commit(1'b0, 0, mk("AB"), '0, 0);

      // Consumer stall for ten cycles.
      send_char("S");
      send_char("T");
      do_commit(1'b1, 7, mk("ST"), mk("SIT"), 10);

      // Reset while waiting on DTW discards the word and any late finish.
      send_char("X");
      send_char("Y");
      send_raw(8'h20);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      mq.delete();
      chk("mid_rst_ready", {127'd0, bus.o_WA_char_ready}, 128'd0);
      chk("mid_rst_start", {127'd0, bus.o_WA_dtw_start}, 128'd0);
      chk("mid_rst_valid", {127'd0, bus.o_WA_word_valid}, 128'd0);
      chk("mid_rst_word", {8'd0, bus.o_WA_word}, 128'd0);
      chk("mid_rst_dtw_word", {8'd0, bus.o_WA_dtw_word}, 128'd0);
      chk("mid_rst_len", {124'd0, bus.o_WA_len}, 128'd0);
      chk("mid_rst_timeout", {127'd0, bus.o_WA_timeout}, 128'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      bus.i_WA_dtw_finish = 1'b1;
      bus.i_WA_dtw_word = mk("XY");
      @(negedge clk);
      bus.i_WA_dtw_finish = 1'b0;
      @(negedge clk);
      chk("late_finish_ignored", {127'd0, bus.o_WA_word_valid}, 128'd0);
      chk("ready_after_late_finish", {127'd0, bus.o_WA_char_ready}, 128'd1);

      // Random words with repeats, backspaces and nulls.
      for (int w = 0; w < 20; w++) begin
         nch = $urandom_range(0, 18);
         for (int j = 0; j < nch; j++) begin
            case ($urandom_range(0, 9))
               0: c = 8'h08;
               1: c = 8'h00;
               default: c = 8'(8'h41 + $urandom_range(0, 3));
            endcase
            send_char(c);
         end
         if (mq.size() > 0) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            do_commit(1'b1, $urandom_range(0, 60), pack_q(), r[119:0], $urandom_range(0, 3));
         end else begin
            send_raw(8'h20);
            chk("rand_empty_no_start", {127'd0, bus.o_WA_dtw_start}, 128'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
